// File: rtl/frame_vote_controller_pkg.sv
// Shared types for the frame vote controller and the image processor it sequences.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frame_vote_controller_pkg;

    localparam int SCREEN_WIDTH_DEF  = 176;
    localparam int SCREEN_HEIGHT_DEF = 144;

    // Vote counters only ever count up to VOTE_FRAMES, which is at most 15
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SHAPE_NONE     = 2'd0,
        SHAPE_SQUARE   = 2'd1,
        SHAPE_TRIANGLE = 2'd2,
        SHAPE_DIAMOND  = 2'd3
    } shape_t;

    typedef enum logic {
        COLOUR_RED  = 1'b0,
        COLOUR_BLUE = 1'b1
    } colour_t;

    typedef struct packed {
        colour_t colour;
        shape_t  shape;
    } vote_t;

    function automatic logic in_active(input logic [9:0] x, input logic [9:0] y,
                                       input int width, input int height);
        return (int'(x) < width) && (int'(y) < height);
    endfunction

endpackage

// File: rtl/frame_vote_tally.sv
// Colour/shape vote counters with combinational majority and argmax.
// Latency: vote reflects the counters including a sample accumulated this cycle.
// Backpressure: none; accumulates whenever accumulate is high.
module frame_vote_tally
    import frame_vote_controller_pkg::*;
#(
    parameter int VOTE_FRAMES = 4
) (
    input  logic  CLK,
    input  logic  RESET,
    input  logic  clear,
    input  logic  accumulate,
    input  vote_t sample,
    output vote_t vote
);

    logic [CNT_W-1:0]      colour_cnt;
    logic [CNT_W-1:0]      colour_cnt_d;
    logic [3:0][CNT_W-1:0] shape_cnt;
    logic [3:0][CNT_W-1:0] shape_cnt_d;
    logic [CNT_W:0]        colour_x2;
    logic [CNT_W-1:0]      best_cnt;
    logic [1:0]            best_idx;

    always_comb begin
        colour_cnt_d = colour_cnt;
        shape_cnt_d  = shape_cnt;
        if (clear) begin
            colour_cnt_d = '0;
            shape_cnt_d  = '0;
        end else if (accumulate) begin
            colour_cnt_d               = colour_cnt + CNT_W'(sample.colour);
            shape_cnt_d[sample.shape]  = shape_cnt[sample.shape] + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            colour_cnt <= '0;
            shape_cnt  <= '0;
        end else begin
            colour_cnt <= colour_cnt_d;
            shape_cnt  <= shape_cnt_d;
        end
    end

    // Strict compare keeps the lowest shape index on ties; exact half goes red
    always_comb begin
        colour_x2 = {colour_cnt_d, 1'b0};
        best_idx  = 2'd0;
        best_cnt  = shape_cnt_d[0];
        for (int i = 1; i < 4; i++) begin
            if (shape_cnt_d[i] > best_cnt) begin
                best_cnt = shape_cnt_d[i];
                best_idx = 2'(i);
            end
        end
        vote.colour = (int'(colour_x2) > VOTE_FRAMES) ? COLOUR_BLUE : COLOUR_RED;
        vote.shape  = shape_t'(best_idx);
    end

endmodule

// File: rtl/frame_vote_controller.sv
// Arms the image processor on REQ, captures VOTE_FRAMES whole frames and returns a voted result.
// Latency: first capture starts at the next vsync rising edge; result one cycle after the last frame ends.
// Backpressure: REQ is a 4-phase level handshake; RESULT is held while REQ stays high.
module frame_vote_controller
    import frame_vote_controller_pkg::*;
#(
    parameter int SCREEN_WIDTH   = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT  = SCREEN_HEIGHT_DEF,
    parameter int VOTE_FRAMES    = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [9:0] VGA_PIXEL_X,
    input  logic [9:0] VGA_PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    input  logic       REQ,
    input  logic [8:0] PROC_RESULT,
    output logic       PROC_CLEAR,
    output logic       PROC_PIXEL_EN,
    output logic       PROC_FRAME_END,
    output logic [2:0] RESULT,
    output logic       RESULT_VALID,
    output logic       TIMEOUT,
    output logic       BUSY
);

    localparam int               WD_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0]  WD_LIMIT      = WD_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] FRAMES_TARGET = CNT_W'(VOTE_FRAMES);

    state_t           state;
    state_t           state_d;
    logic             vsync_q;
    logic             fb;
    logic             active_px;
    logic [WD_W-1:0]  wdog;
    logic [WD_W-1:0]  wdog_d;
    logic             wdog_expire;
    logic [CNT_W-1:0] frames_done;
    logic [CNT_W-1:0] frames_done_d;
    vote_t            vote;
    vote_t            result_q;
    vote_t            result_d;
    logic             timeout_q;
    logic             timeout_d;
    logic             tally_clear;
    logic             tally_acc;
    logic             proc_result_unused;

    assign proc_result_unused = ^PROC_RESULT[8:3];

    // History resets high so a VSYNC_NEG already high at release is not an edge
    assign fb        = ~vsync_q & VGA_VSYNC_NEG;
    assign active_px = in_active(VGA_PIXEL_X, VGA_PIXEL_Y, SCREEN_WIDTH, SCREEN_HEIGHT);

    frame_vote_tally #(
        .VOTE_FRAMES (VOTE_FRAMES)
    ) u_tally (
        .CLK        (CLK),
        .RESET      (RESET),
        .clear      (tally_clear),
        .accumulate (tally_acc),
        .sample     (vote_t'(PROC_RESULT[2:0])),
        .vote       (vote)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= ST_IDLE;
            vsync_q     <= 1'b1;
            wdog        <= '0;
            frames_done <= '0;
            result_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_d;
            vsync_q     <= VGA_VSYNC_NEG;
            wdog        <= wdog_d;
            frames_done <= frames_done_d;
            result_q    <= result_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d        = state;
        frames_done_d  = frames_done;
        wdog_d         = '0;
        wdog_expire    = 1'b0;
        result_d       = result_q;
        timeout_d      = timeout_q;
        tally_clear    = 1'b0;
        tally_acc      = 1'b0;
        PROC_CLEAR     = 1'b0;
        PROC_PIXEL_EN  = 1'b0;
        PROC_FRAME_END = 1'b0;

        if (state == ST_ARM || state == ST_CAPTURE) begin
            wdog_d      = fb ? '0 : wdog + 1'b1;
            wdog_expire = !fb && (wdog_d == WD_LIMIT);
        end

        case (state)
            ST_IDLE: begin
                tally_clear   = 1'b1;
                frames_done_d = '0;
                result_d      = '0;
                timeout_d     = 1'b0;
                if (REQ) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!REQ) begin
                    state_d = ST_IDLE;
                end else if (fb) begin
                    PROC_CLEAR = 1'b1;
                    state_d    = ST_CAPTURE;
                end else if (wdog_expire) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_CAPTURE: begin
                PROC_PIXEL_EN = active_px && !fb;
                if (!REQ) begin
                    state_d = ST_IDLE;
                end else if (fb) begin
                    PROC_FRAME_END = 1'b1;
                    state_d        = ST_LATCH;
                end else if (wdog_expire) begin
                    result_d  = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            ST_LATCH: begin
                if (!REQ) begin
                    state_d = ST_IDLE;
                end else begin
                    tally_acc     = 1'b1;
                    frames_done_d = frames_done + 1'b1;
                    if (frames_done_d == FRAMES_TARGET) begin
                        result_d = vote;
                        state_d  = ST_DONE;
                    end else begin
                        // The boundary that ended this frame also started the next one
                        PROC_CLEAR = 1'b1;
                        state_d    = ST_CAPTURE;
                    end
                end
            end
            ST_DONE: begin
                if (!REQ) begin
                    result_d  = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != ST_ARM && state_d != ST_CAPTURE) begin
            wdog_d = '0;
        end
    end

    assign RESULT       = result_q;
    assign TIMEOUT      = timeout_q;
    assign RESULT_VALID = (state == ST_DONE);
    assign BUSY         = (state == ST_ARM) || (state == ST_CAPTURE) || (state == ST_LATCH);

endmodule

// File: tb/tb_frame_vote_controller.sv
// Randomised frame/vote scenarios for frame_vote_controller against a counting reference model.
module tb_frame_vote_controller;

    localparam int V  = 4;
    localparam int TO = 100;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [9:0] VGA_PIXEL_X;
    logic [9:0] VGA_PIXEL_Y;
    logic       VGA_VSYNC_NEG;
    logic       REQ;
    logic [8:0] PROC_RESULT;
    logic       PROC_CLEAR;
    logic       PROC_PIXEL_EN;
    logic       PROC_FRAME_END;
    logic [2:0] RESULT;
    logic       RESULT_VALID;
    logic       TIMEOUT;
    logic       BUSY;

    int vectors     = 0;
    int miscompares = 0;
    int n_clear     = 0;
    int n_fend      = 0;
    logic [2:0] smp [V];

    always #5 CLK = ~CLK;

    frame_vote_controller #(
        .SCREEN_WIDTH   (176),
        .SCREEN_HEIGHT  (144),
        .VOTE_FRAMES    (V),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .VGA_PIXEL_X    (VGA_PIXEL_X),
        .VGA_PIXEL_Y    (VGA_PIXEL_Y),
        .VGA_VSYNC_NEG  (VGA_VSYNC_NEG),
        .REQ            (REQ),
        .PROC_RESULT    (PROC_RESULT),
        .PROC_CLEAR     (PROC_CLEAR),
        .PROC_PIXEL_EN  (PROC_PIXEL_EN),
        .PROC_FRAME_END (PROC_FRAME_END),
        .RESULT         (RESULT),
        .RESULT_VALID   (RESULT_VALID),
        .TIMEOUT        (TIMEOUT),
        .BUSY           (BUSY)
    );

    // Reference: majority colour (strictly more than half blue), most frequent shape, lowest code on ties
    function automatic logic [2:0] ref_vote();
        int blue = 0;
        int cnt [4];
        int best = 0;
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        for (int i = 0; i < V; i++) begin
            blue += int'(smp[i][2]);
            cnt[smp[i][1:0]] += 1;
        end
        for (int s = 1; s < 4; s++) if (cnt[s] > cnt[best]) best = s;
        return {(2 * blue > V), 2'(best)};
    endfunction

    function automatic logic [9:0] rx();
        return 10'($urandom_range(160, 190));
    endfunction

    function automatic logic [9:0] ry();
        return 10'($urandom_range(130, 155));
    endfunction

    task automatic tick(input logic req, input logic vs, input logic [9:0] x,
                        input logic [9:0] y, input logic [8:0] pr);
        @(posedge CLK);
        #1;
        REQ           = req;
        VGA_VSYNC_NEG = vs;
        VGA_PIXEL_X   = x;
        VGA_PIXEL_Y   = y;
        PROC_RESULT   = pr;
        @(negedge CLK);
        n_clear += int'(PROC_CLEAR);
        n_fend  += int'(PROC_FRAME_END);
        vectors++;
        if (BUSY && RESULT_VALID) begin
            miscompares++;
            $display("FAIL busy_and_valid: BUSY=%b RESULT_VALID=%b, required not both high", BUSY, RESULT_VALID);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 1'b1, rx(), ry(), 9'($urandom));
            vectors++;
            if (RESULT_VALID !== 1'b0 || BUSY !== 1'b0 || PROC_PIXEL_EN !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_quiet: valid=%b busy=%b pix=%b, required 0 0 0", RESULT_VALID, BUSY, PROC_PIXEL_EN);
            end
        end
    endtask

    // One request: partial frame, then V captured frames; optional abort in frame abort_frame+1
    task automatic run_vote(input int abort_frame, input bit abort_on_fb);
        int h;
        int l;
        int idx;
        int exp_fend;
        logic [9:0] x;
        logic [9:0] y;
        logic [8:0] pr;
        logic exp_en;
        logic [2:0] exp_res;
        exp_res = ref_vote();
        n_clear = 0;
        n_fend  = 0;
        for (int c = 0; c < 9; c++) begin
            tick(1'b1, c < 6, 10'($urandom_range(0, 175)), 10'($urandom_range(0, 143)), 9'($urandom));
            vectors++;
            if (PROC_PIXEL_EN !== 1'b0) begin
                miscompares++;
                $display("FAIL no_partial_frame: c=%0d pix=%b, required 0", c, PROC_PIXEL_EN);
            end
            if (c == 0) begin
                vectors++;
                if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_on_req: busy=%b valid=%b, required 0 0", BUSY, RESULT_VALID);
                end
            end
            if (c == 1) begin
                vectors++;
                if (BUSY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL busy_armed: busy=%b, required 1", BUSY);
                end
            end
        end
        for (int f = 1; f <= V + 1; f++) begin
            h = $urandom_range(20, 40);
            l = $urandom_range(2, 5);
            for (int c = 0; c < h + l; c++) begin
                x   = rx();
                y   = ry();
                idx = (c >= 2) ? f : f - 1;
                pr  = {6'($urandom), (idx >= 1 && idx <= V) ? smp[idx-1] : 3'($urandom)};
                if (f == V + 1 && c == 6) begin
                    vectors++;
                    if (n_fend !== V) begin
                        miscompares++;
                        $display("FAIL frame_end_count: got %0d, required %0d", n_fend, V);
                    end
                    vectors++;
                    if (n_clear !== V) begin
                        miscompares++;
                        $display("FAIL clear_count: got %0d, required %0d", n_clear, V);
                    end
                    tick(1'b0, 1'b1, x, y, pr);
                    vectors++;
                    if (RESULT_VALID !== 1'b1 || RESULT !== exp_res) begin
                        miscompares++;
                        $display("FAIL hold_until_req_low: valid=%b result=%b, required 1 %b", RESULT_VALID, RESULT, exp_res);
                    end
                    return;
                end
                if (abort_frame != 0 && f == abort_frame + 1 && c == (abort_on_fb ? 0 : h / 2)) begin
                    exp_fend = (c == 0) ? f - 2 : f - 1;
                    tick(1'b0, c < h, x, y, pr);
                    vectors++;
                    if (PROC_FRAME_END !== 1'b0) begin
                        miscompares++;
                        $display("FAIL abort_no_frame_end: got %b, required 0", PROC_FRAME_END);
                    end
                    tick(1'b0, 1'b1, x, y, pr);
                    vectors++;
                    if (BUSY !== 1'b0 || RESULT_VALID !== 1'b0) begin
                        miscompares++;
                        $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", BUSY, RESULT_VALID);
                    end
                    idle(30);
                    vectors++;
                    if (n_fend !== exp_fend) begin
                        miscompares++;
                        $display("FAIL abort_frame_end_count: got %0d, required %0d", n_fend, exp_fend);
                    end
                    return;
                end
                tick(1'b1, c < h, x, y, pr);
                exp_en = (f <= V) && (x < 10'd176) && (y < 10'd144) && (c != 0) && !(c == 1 && f >= 2);
                vectors++;
                if (PROC_PIXEL_EN !== exp_en) begin
                    miscompares++;
                    $display("FAIL pixel_en: f=%0d c=%0d x=%0d y=%0d got %b, required %b", f, c, x, y, PROC_PIXEL_EN, exp_en);
                end
                if (f == V + 1 && c == 1) begin
                    vectors++;
                    if (RESULT_VALID !== 1'b0) begin
                        miscompares++;
                        $display("FAIL valid_early: got %b, required 0", RESULT_VALID);
                    end
                end
                if (f == V + 1 && c >= 2) begin
                    vectors++;
                    if (RESULT_VALID !== 1'b1 || RESULT !== exp_res || TIMEOUT !== 1'b0) begin
                        miscompares++;
                        $display("FAIL vote_result: valid=%b result=%b timeout=%b, required 1 %b 0", RESULT_VALID, RESULT, TIMEOUT, exp_res);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        REQ = 1'b0; VGA_VSYNC_NEG = 1'b1; VGA_PIXEL_X = '0; VGA_PIXEL_Y = '0; PROC_RESULT = '0;
        #2 RESET = 1'b1;
        #2;
        vectors++;
        if ({PROC_CLEAR, PROC_PIXEL_EN, PROC_FRAME_END, RESULT, RESULT_VALID, TIMEOUT, BUSY} !== 9'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b, required all 0",
                     {PROC_CLEAR, PROC_PIXEL_EN, PROC_FRAME_END, RESULT, RESULT_VALID, TIMEOUT, BUSY});
        end
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        idle(3);
    endtask

    task automatic test_basic_vote();
        smp[0] = 3'b101; smp[1] = 3'b101; smp[2] = 3'b110; smp[3] = 3'b101;
        run_vote(0, 1'b0);
        idle(3);
    endtask

    task automatic test_tie();
        smp[0] = 3'b101; smp[1] = 3'b011; smp[2] = 3'b111; smp[3] = 3'b001;
        run_vote(0, 1'b0);
        idle(2);
    endtask

    task automatic test_abort();
        for (int i = 0; i < V; i++) smp[i] = 3'b111;
        run_vote(2, 1'b0);
        for (int i = 0; i < V; i++) smp[i] = 3'($urandom);
        run_vote(0, 1'b0);
        idle(2);
        run_vote(2, 1'b1);
        for (int i = 0; i < V; i++) smp[i] = 3'($urandom_range(0, 4));
        run_vote(0, 1'b0);
        idle(2);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < V; i++) smp[i] = 3'($urandom);
            run_vote(0, 1'b0);
        end
        idle(2);
    endtask

    task automatic test_timeout();
        n_clear = 0;
        for (int k = 0; k <= TO + 1; k++) begin
            tick(1'b1, 1'b1, rx(), ry(), 9'($urandom));
            vectors++;
            if (k <= TO) begin
                if (RESULT_VALID !== 1'b0 || BUSY !== (k >= 1)) begin
                    miscompares++;
                    $display("FAIL timeout_wait: k=%0d valid=%b busy=%b, required 0 %b", k, RESULT_VALID, BUSY, (k >= 1));
                end
            end else if (RESULT_VALID !== 1'b1 || TIMEOUT !== 1'b1 || RESULT !== 3'd0) begin
                miscompares++;
                $display("FAIL timeout_fire: valid=%b timeout=%b result=%b, required 1 1 000", RESULT_VALID, TIMEOUT, RESULT);
            end
        end
        vectors++;
        if (n_clear !== 0) begin
            miscompares++;
            $display("FAIL timeout_no_clear: got %0d clears, required 0", n_clear);
        end
        tick(1'b0, 1'b1, rx(), ry(), 9'd0);
        vectors++;
        if (RESULT_VALID !== 1'b1 || TIMEOUT !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_hold: valid=%b timeout=%b, required 1 1", RESULT_VALID, TIMEOUT);
        end
        tick(1'b0, 1'b1, rx(), ry(), 9'd0);
        vectors++;
        if (RESULT_VALID !== 1'b0 || TIMEOUT !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: valid=%b timeout=%b, required 0 0", RESULT_VALID, TIMEOUT);
        end
        idle(2);
    endtask

    task automatic test_reset_mid_capture();
        logic [9:0] wx [5];
        logic [9:0] wy [5];
        logic       we [5];
        wx = '{10'd175, 10'd176, 10'd0,   10'd175, 10'd100};
        wy = '{10'd143, 10'd0,   10'd144, 10'd144, 10'd50};
        we = '{1'b1,    1'b0,    1'b0,    1'b0,    1'b1};
        for (int c = 0; c < 4; c++) tick(1'b1, 1'b1, 10'd10, 10'd10, 9'd0);
        tick(1'b1, 1'b0, 10'd10, 10'd10, 9'd0);
        tick(1'b1, 1'b0, 10'd10, 10'd10, 9'd0);
        tick(1'b1, 1'b1, 10'd300, 10'd300, 9'd0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1, wx[i], wy[i], 9'd0);
            vectors++;
            if (PROC_PIXEL_EN !== we[i]) begin
                miscompares++;
                $display("FAIL window_edge: x=%0d y=%0d got %b, required %b", wx[i], wy[i], PROC_PIXEL_EN, we[i]);
            end
        end
        @(posedge CLK);
        #1;
        VGA_PIXEL_X = 10'd100; VGA_PIXEL_Y = 10'd50;
        #1;
        vectors++;
        if (PROC_PIXEL_EN !== 1'b1 || BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_capture: pix=%b busy=%b, required 1 1", PROC_PIXEL_EN, BUSY);
        end
        RESET = 1'b1;
        #1;
        vectors++;
        if ({PROC_CLEAR, PROC_PIXEL_EN, PROC_FRAME_END, RESULT, RESULT_VALID, TIMEOUT, BUSY} !== 9'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b, required all 0",
                     {PROC_CLEAR, PROC_PIXEL_EN, PROC_FRAME_END, RESULT, RESULT_VALID, TIMEOUT, BUSY});
        end
        @(posedge CLK);
        @(posedge CLK);
        #1 RESET = 1'b0;
        n_clear = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b1, 10'd100, 10'd50, 9'd0);
            vectors++;
            if (PROC_CLEAR !== 1'b0 || PROC_PIXEL_EN !== 1'b0 || BUSY !== 1'b1) begin
                miscompares++;
                $display("FAIL no_false_fb: k=%0d clear=%b pix=%b busy=%b, required 0 0 1", k, PROC_CLEAR, PROC_PIXEL_EN, BUSY);
            end
        end
        tick(1'b0, 1'b1, 10'd0, 10'd0, 9'd0);
        idle(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_vote();
        test_tie();
        test_abort();
        test_back_to_back();
        test_timeout();
        test_reset_mid_capture();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_vote_controller.md
Name: frame_vote_controller

Overview:
- Sequences the camera image processor on behalf of the Arduino.
- On request it waits for a clean frame boundary, then gates and clears the processor once per frame.
- It samples the processor's per-frame colour/shape code and majority-votes over VOTE_FRAMES frames.
- It returns one voted result through a 4-phase REQ/RESULT_VALID handshake.
- Sits between VGA/camera timing, the image processor and the Arduino GPIO output.

Parameters:
- SCREEN_WIDTH, 176, active pixels per line.
- SCREEN_HEIGHT, 144, active lines per frame.
- VOTE_FRAMES, 4, frames voted per request (1..15).
- TIMEOUT_CYCLES, 1000000, max CLK cycles allowed between frame boundaries while ARM/CAPTURE.

Ports:
- CLK  in  1  pixel-domain clock.
- RESET  in  1  asynchronous, active-high reset.
- VGA_PIXEL_X  in  10  current pixel column.
- VGA_PIXEL_Y  in  10  current pixel row.
- VGA_VSYNC_NEG  in  1  vsync, low during the sync pulse.
- REQ  in  1  Arduino classification request, level.
- PROC_RESULT  in  9  processor result; [2]=colour (0 red, 1 blue), [1:0]=shape code; [8:3] ignored.
- PROC_CLEAR  out  1  1-cycle pulse, processor clears its accumulators.
- PROC_PIXEL_EN  out  1  current pixel belongs to the captured frame.
- PROC_FRAME_END  out  1  1-cycle pulse, captured frame complete.
- RESULT  out  3  voted {colour, shape[1:0]}.
- RESULT_VALID  out  1  RESULT stable and valid.
- TIMEOUT  out  1  qualifies RESULT_VALID: camera timing lost, RESULT=0.
- BUSY  out  1  high in ARM, CAPTURE, LATCH.

Behaviour:
- Reset (async, high):
  - state=IDLE; all outputs 0.
  - Vote counters, frame counter and watchdog cleared.
  - vsync history register set to 1, so there is no spurious edge after release.
- Frame boundary (fb): rising edge of VGA_VSYNC_NEG, i.e. registered copy 0 and current 1. One cycle of detection latency.
- States: IDLE, ARM, CAPTURE, LATCH, DONE.
- IDLE:
  - REQ=1 -> ARM.
  - Clears vote counters, frame counter and watchdog on entry.
- ARM:
  - Waits for fb. On the fb cycle, PROC_CLEAR=1 for that cycle -> CAPTURE.
  - Never captures a partial frame.
- CAPTURE:
  - PROC_PIXEL_EN = (VGA_PIXEL_X < SCREEN_WIDTH) && (VGA_PIXEL_Y < SCREEN_HEIGHT), combinational from inputs.
  - On fb: PROC_FRAME_END=1 for one cycle, PROC_PIXEL_EN forced 0 -> LATCH.
- LATCH (exactly 1 cycle):
  - PROC_PIXEL_EN=0.
  - Sample PROC_RESULT[2:0].
  - colour_cnt += PROC_RESULT[2].
  - shape_cnt[PROC_RESULT[1:0]] += 1.
  - frames_done += 1.
  - If frames_done (post-increment) == VOTE_FRAMES -> DONE.
  - Else PROC_CLEAR=1 this cycle -> CAPTURE. The next frame is the one fb just started, so there is no gap frame.
- DONE:
  - RESULT[2] = (2*colour_cnt > VOTE_FRAMES); a tie gives red (0).
  - RESULT[1:0] = index of the maximum shape_cnt; ties go to the lowest index.
  - RESULT registered on entry to DONE, RESULT_VALID=1 from the first DONE cycle.
  - RESULT held until REQ=0 -> IDLE; RESULT_VALID falls the cycle after REQ sampled low.
- Abort:
  - REQ=0 in ARM/CAPTURE/LATCH -> IDLE next cycle.
  - No RESULT_VALID, no PROC_FRAME_END; counters cleared.
- Watchdog:
  - Counts CLK in ARM/CAPTURE; cleared on every fb and on leaving those states.
  - Reaching TIMEOUT_CYCLES -> DONE with RESULT=0, TIMEOUT=1.
  - TIMEOUT clears with RESULT_VALID.
- Simultaneous events:
  - REQ falling on the same cycle as fb: abort wins, no PROC_FRAME_END.
  - REQ re-asserted in the IDLE cycle after DONE starts a fresh vote.
- Widths:
  - shape_cnt, colour_cnt and frames_done are 4 bits and cannot overflow, since VOTE_FRAMES ≤ 15.
  - Watchdog width is clog2(TIMEOUT_CYCLES+1).
- RESULT is stable whenever RESULT_VALID=1; BUSY and RESULT_VALID are never both high.

Decomposition:
- Shared package:
  - State encoding constants.
  - Shape codes: 0 none, 1 square, 2 triangle, 3 diamond.
  - Colour codes.
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults, also used by the image processor.
- Sub-module frame_vote_tally: holds the colour/shape counters, clear/accumulate inputs and the combinational argmax/majority. The controller keeps the FSM, edge detect and watchdog.

Test Plan:
- Reset mid-CAPTURE -> all outputs 0 in the same cycle, state IDLE; no fb falsely detected after release with VSYNC_NEG=1.
- REQ=1, 4 frames with PROC_RESULT=3'b101,3'b101,3'b110,3'b101 -> RESULT=3'b101, RESULT_VALID=1; exactly 4 PROC_FRAME_END and 4 PROC_CLEAR pulses.
- Colour tie 2/2 and shape tie square=2/diamond=2 -> RESULT=3'b001.
- REQ asserted mid-frame -> no PROC_PIXEL_EN until the next fb; pixel at X=176 or Y=144 -> PROC_PIXEL_EN=0.
- REQ dropped after 2 frames -> IDLE next cycle, no RESULT_VALID; the new REQ vote ignores the earlier frames.
- VSYNC held constant with TIMEOUT_CYCLES=100 -> at cycle 100 RESULT_VALID=1, TIMEOUT=1, RESULT=0; REQ=0 clears both.
